mem_lsu: RTL and testbench
==========================

# mem_lsu

Parametrised memory-stage load/store unit; sits between EX and WB in place of the single-load memory stage. Issues data-RAM requests with a req/gnt handshake. Tracks up to DEPTH in-flight ops in an in-order FIFO, so several loads can be outstanding at once. Adds store byte-lane generation, RV64 loads, misalignment traps and flush-safe response draining.

## Interface
- XLEN, 32: data width, 32 or 64 (64 enables size D and LWU).
- REG_AW, 5: register address width.
- DEPTH, 2: tracking FIFO entries, 1/2/4.
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- ex_valid, ex_ready  in/out  1  EX→LSU handshake.
- ex_pc, ex_addr, ex_wdata, ex_alu_result  input  XLEN  op PC, effective address, store data, ALU result.
- ex_mem_read, ex_mem_write, ex_unsign  input  1  load, store, zero-extend.
- ex_size  input  2  0=B 1=H 2=W 3=D.
- ex_rd_write  input  1  rd write enable.
- ex_rd_addr  input  REG_AW  rd address.
- flush  input  1  drop all ops held or presented.
- dram_req, dram_we  output  1  request, write.
- dram_gnt  input  1  request accepted.
- dram_addr  output  XLEN  ex_addr aligned down to XLEN/8.
- dram_wdata  output  XLEN  lane-shifted store data.
- dram_wstrb  output  XLEN/8  byte enables.
- dram_rvalid  input  1  load response, strictly in request order.
- dram_rdata  input  XLEN  load response data.
- wb_valid, wb_ready  out/in  1  LSU→WB handshake.
- wb_pc, wb_rd_data  output  XLEN  head PC, head result.
- wb_rd_write  output  1  head rd write enable.
- wb_rd_addr  output  REG_AW  head rd address.
- wb_exc  output  1  head raised a trap.
- wb_exc_code  output  4  4=load misaligned, 6=store misaligned.
- wb_exc_tval  output  XLEN  faulting address.
- mem_rd_write, mem_rd_addr, mem_rd_wdata  output  1/REG_AW/XLEN  forward from head; mem_rd_write = wb_valid & wb_rd_write.
- mem_hazard  output  1  any entry has rd_write and is not yet forwardable.

## Operation
- Entry fields: pc, rd_write, rd_addr, size, unsign, offset, is_load, done, exc, exc_code, tval, data. Pointers wrap mod DEPTH. Occupancy count 0..DEPTH.
- Accept: ex_valid & ex_ready & ~flush pushes one entry.
- Misaligned check: offset not a multiple of 2^size. Such an op issues no request and pushes done=1 with exc=1; exc_code 4 for loads, 6 for stores; tval = ex_addr.
- Non-memory op: pushes done=1, data = ex_alu_result.
- Aligned load or store: dram_req = ex_valid & ~full & ~flush.
  - A load additionally requires discard count < 3.
  - A store additionally requires the FIFO to be empty.
  - ex_ready = dram_gnt for these ops. ex_ready = ~full for non-memory and misaligned ops.
- Accepted store: pushes done=1 with no response expected. wstrb covers 2^size bytes at the offset; wdata is replicated into the lanes.
- Accepted load: pushes done=0.
- dram_rvalid with discard count 0: fills the oldest un-done load entry via the response pointer.
  - Extraction per size and offset, sign- or zero-extended by unsign.
  - XLEN=32 never receives size 3.
- Pop: wb_valid & wb_ready. wb_valid = head present & head done. All wb_* fields come from the head entry.
- Flush, same cycle:
  - Clears the FIFO.
  - Discard count += number of un-done loads in the FIFO, minus 1 if dram_rvalid is high that cycle and the count was 0.
- Discard count > 0: each dram_rvalid decrements it; the data is dropped. Counter is 3 bits.
- mem_hazard = OR over entries of rd_write & (~done | ~head). ID stalls on a matching rd.

## Timing
- Reset values: FIFO empty, discard count 0, wb_valid 0, dram_req 0, mem_hazard 0, mem_rd_write 0, wb_exc 0. Data fields are don't-care.
- Non-memory or trapping op accepted at edge N: wb_valid high in cycle N+1.
- Load rvalid at edge M: wb_valid high in cycle M+1 if that entry is head. Back-to-back rvalids fill successive entries.
- Full FIFO: ex_ready=0 even if a pop occurs the same cycle (no bypass).
- Push and pop in the same cycle: occupancy unchanged.
- dram_rvalid with no un-done load and discard count 0: ignored (protocol violation).
- Reset mid-load: outstanding responses are not tracked; the RAM must also be reset.
- Stores become visible at grant and cannot be recalled. The trap unit holds stores in EX while a flush is pending.

## Test plan
- Load latency: XLEN=32; LW addr 0x100, gnt immediate, rvalid 3 cycles later with 0x8000_00F1 → wb_rd_data 0x8000_00F1 one cycle after rvalid. Then LB at offset 0 → 0xFFFF_FFF1; LBU → 0x0000_00F1.
- Outstanding loads: DEPTH=2, two LW to 0x200 and 0x204 granted on consecutive cycles, responses A then B → WB retires A then B; ex_ready=0 for a third op until the first pop.
- Store lanes: SH addr 0x102 data 0x1234 → wstrb 4'b1100, wdata[31:16]=0x1234, dram_we=1, entry retires with no rvalid.
- Misalignment: LW addr 0x101 → no dram_req; wb_exc=1, code 4, tval 0x101. SW addr 0x102 → code 6.
- Flush drain: two loads outstanding, flush asserted, then a new LW issued → first two rvalids dropped; third rvalid (0xCAFE) retires as the new load's result.
- RV64: XLEN=64; LD addr 0x8 → full 64-bit data. LWU offset 4 with rdata[63:32]=0xFFFF_0000 → 0x0000_0000_FFFF_0000.

Source files
------------

// File: rtl/mem_lsu.sv
// In-order memory-stage load/store unit: issues data-RAM requests, tracks up to
// DEPTH in-flight ops, extracts load data, generates store lanes and drains flushed responses.
module mem_lsu #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [XLEN-1:0]     ex_pc,
    input  logic [XLEN-1:0]     ex_addr,
    input  logic [XLEN-1:0]     ex_wdata,
    input  logic [XLEN-1:0]     ex_alu_result,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic                ex_unsign,
    input  logic [1:0]          ex_size,
    input  logic                ex_rd_write,
    input  logic [REG_AW-1:0]   ex_rd_addr,
    input  logic                flush,
    output logic                dram_req,
    output logic                dram_we,
    input  logic                dram_gnt,
    output logic [XLEN-1:0]     dram_addr,
    output logic [XLEN-1:0]     dram_wdata,
    output logic [XLEN/8-1:0]   dram_wstrb,
    input  logic                dram_rvalid,
    input  logic [XLEN-1:0]     dram_rdata,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [XLEN-1:0]     wb_pc,
    output logic [XLEN-1:0]     wb_rd_data,
    output logic                wb_rd_write,
    output logic [REG_AW-1:0]   wb_rd_addr,
    output logic                wb_exc,
    output logic [3:0]          wb_exc_code,
    output logic [XLEN-1:0]     wb_exc_tval,
    output logic                mem_rd_write,
    output logic [REG_AW-1:0]   mem_rd_addr,
    output logic [XLEN-1:0]     mem_rd_wdata,
    output logic                mem_hazard
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]   pc_q       [DEPTH];
    logic [XLEN-1:0]   tval_q     [DEPTH];
    logic [XLEN-1:0]   data_q     [DEPTH];
    logic [REG_AW-1:0] rd_addr_q  [DEPTH];
    logic [1:0]        size_q     [DEPTH];
    logic [OFF_W-1:0]  offset_q   [DEPTH];
    logic [3:0]        exc_code_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, done_q, rd_write_q, unsign_q, is_load_q, exc_q;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, rsp_idx, scan_idx;
    logic [CNT_W-1:0] count_q, count_d, undone_cnt;
    logic [2:0]       disc_q, disc_d;

    logic [OFF_W-1:0] ex_off;
    logic [3:0]       size_mask;
    logic             misaligned, aligned_ld, aligned_st, is_aligned_mem;
    logic             full, empty, mem_ok, push, pop, fill, rsp_found;
    logic [XLEN-1:0]  rsp_shift, load_data;
    int               rsp_nbits, lane_bytes;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (DEPTH == 1 || int'(p) == DEPTH - 1) return '0;
        return p + 1'b1;
    endfunction

    assign ex_off         = ex_addr[OFF_W-1:0];
    assign size_mask      = (4'd1 << ex_size) - 4'd1;
    assign misaligned     = (ex_mem_read | ex_mem_write) & (|(ex_off & size_mask[OFF_W-1:0]));
    assign aligned_ld     = ex_mem_read & ~misaligned;
    assign aligned_st     = ex_mem_write & ~ex_mem_read & ~misaligned;
    assign is_aligned_mem = aligned_ld | aligned_st;
    assign full           = (count_q == CNT_W'(DEPTH));
    assign empty          = (count_q == '0);

    // Stores wait for an empty FIFO so they never overtake an older load's response.
    assign mem_ok   = ~full & ~flush & (aligned_ld ? (disc_q < 3'd3) : empty);
    assign dram_req = ex_valid & is_aligned_mem & mem_ok;
    assign dram_we  = aligned_st;
    assign ex_ready = is_aligned_mem ? (dram_gnt & mem_ok) : ~full;
    assign dram_addr = {ex_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};

    assign push = ex_valid & ex_ready & ~flush;
    assign pop  = wb_valid & wb_ready & ~flush;
    assign fill = dram_rvalid & (disc_q == 3'd0) & rsp_found & ~flush;

    always_comb begin
        lane_bytes = 1 << ex_size;
        dram_wdata = '0;
        dram_wstrb = '0;
        for (int j = 0; j < NB; j++) begin
            dram_wdata[8*j +: 8] = ex_wdata[8*(j % lane_bytes) +: 8];
            dram_wstrb[j]        = (j >= int'(ex_off)) && (j < int'(ex_off) + lane_bytes);
        end
    end

    // Scan from the youngest back to the head so the oldest un-done load wins.
    always_comb begin
        rsp_found  = 1'b0;
        rsp_idx    = head_q;
        scan_idx   = '0;
        undone_cnt = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            scan_idx = PTR_W'((int'(head_q) + k) % DEPTH);
            if (valid_q[scan_idx] && is_load_q[scan_idx] && !done_q[scan_idx]) begin
                rsp_found  = 1'b1;
                rsp_idx    = scan_idx;
                undone_cnt = undone_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        rsp_shift = dram_rdata >> {offset_q[rsp_idx], 3'b000};
        rsp_nbits = 8 << size_q[rsp_idx];
        if (rsp_nbits > XLEN) rsp_nbits = XLEN;
        load_data = '0;
        for (int b = 0; b < XLEN; b++)
            load_data[b] = (b < rsp_nbits) ? rsp_shift[b]
                                           : (~unsign_q[rsp_idx] & rsp_shift[rsp_nbits-1]);
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        disc_d  = disc_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            disc_d  = disc_q + 3'(undone_cnt)
                    - ((dram_rvalid && (disc_q != 3'd0 || undone_cnt != '0)) ? 3'd1 : 3'd0);
        end else begin
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            if (dram_rvalid && disc_q != 3'd0) disc_d = disc_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            disc_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            disc_q  <= disc_d;
            if (flush) begin
                valid_q <= '0;
            end else begin
                if (pop) valid_q[head_q] <= 1'b0;
                if (push) begin
                    valid_q[tail_q] <= 1'b1;
                    done_q[tail_q]  <= ~aligned_ld;
                end
                if (fill) done_q[rsp_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail_q]       <= ex_pc;
            tval_q[tail_q]     <= ex_addr;
            data_q[tail_q]     <= ex_alu_result;
            rd_addr_q[tail_q]  <= ex_rd_addr;
            size_q[tail_q]     <= ex_size;
            offset_q[tail_q]   <= ex_off;
            exc_code_q[tail_q] <= ex_mem_read ? 4'd4 : 4'd6;
            rd_write_q[tail_q] <= ex_rd_write;
            unsign_q[tail_q]   <= ex_unsign;
            is_load_q[tail_q]  <= aligned_ld;
            exc_q[tail_q]      <= misaligned;
        end
        if (fill) data_q[rsp_idx] <= load_data;
    end

    assign wb_valid     = valid_q[head_q] & done_q[head_q];
    assign wb_pc        = pc_q[head_q];
    assign wb_rd_data   = data_q[head_q];
    assign wb_rd_write  = rd_write_q[head_q];
    assign wb_rd_addr   = rd_addr_q[head_q];
    assign wb_exc       = wb_valid & exc_q[head_q];
    assign wb_exc_code  = exc_code_q[head_q];
    assign wb_exc_tval  = tval_q[head_q];
    assign mem_rd_write = wb_valid & wb_rd_write;
    assign mem_rd_addr  = wb_rd_addr;
    assign mem_rd_wdata = wb_rd_data;

    always_comb begin
        mem_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (valid_q[i] && rd_write_q[i] && (!done_q[i] || PTR_W'(i) != head_q))
                mem_hazard = 1'b1;
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a 32-bit DEPTH=2 instance and a 64-bit instance.
module tb_mem_lsu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // 32-bit instance signals
    logic        s_ex_valid, s_ex_ready, s_mem_read, s_mem_write, s_unsign, s_rd_write;
    logic [31:0] s_pc, s_addr, s_wdata, s_alu;
    logic [1:0]  s_size;
    logic [4:0]  s_rd_addr;
    logic        s_flush, s_req, s_we, s_gnt, s_rvalid;
    logic [31:0] s_daddr, s_dwdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_wb_valid, s_wb_ready, s_wb_rd_write, s_wb_exc, s_fwd_write, s_hazard;
    logic [31:0] s_wb_pc, s_wb_data, s_wb_tval, s_fwd_data;
    logic [4:0]  s_wb_rd_addr, s_fwd_addr;
    logic [3:0]  s_wb_code;

    // 64-bit instance signals
    logic        d_ex_valid, d_ex_ready, d_mem_read, d_mem_write, d_unsign, d_rd_write;
    logic [63:0] d_pc, d_addr, d_wdata, d_alu;
    logic [1:0]  d_size;
    logic [4:0]  d_rd_addr;
    logic        d_flush, d_req, d_we, d_gnt, d_rvalid;
    logic [63:0] d_daddr, d_dwdata, d_rdata;
    logic [7:0]  d_wstrb;
    logic        d_wb_valid, d_wb_ready, d_wb_rd_write, d_wb_exc, d_fwd_write, d_hazard;
    logic [63:0] d_wb_pc, d_wb_data, d_wb_tval, d_fwd_data;
    logic [4:0]  d_wb_rd_addr, d_fwd_addr;
    logic [3:0]  d_wb_code;

    mem_lsu #(.XLEN(32), .REG_AW(5), .DEPTH(2)) u_dut32 (
        .clk(clk), .rst(rst), .ex_valid(s_ex_valid), .ex_ready(s_ex_ready),
        .ex_pc(s_pc), .ex_addr(s_addr), .ex_wdata(s_wdata), .ex_alu_result(s_alu),
        .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write), .ex_unsign(s_unsign),
        .ex_size(s_size), .ex_rd_write(s_rd_write), .ex_rd_addr(s_rd_addr), .flush(s_flush),
        .dram_req(s_req), .dram_we(s_we), .dram_gnt(s_gnt), .dram_addr(s_daddr),
        .dram_wdata(s_dwdata), .dram_wstrb(s_wstrb), .dram_rvalid(s_rvalid), .dram_rdata(s_rdata),
        .wb_valid(s_wb_valid), .wb_ready(s_wb_ready), .wb_pc(s_wb_pc), .wb_rd_data(s_wb_data),
        .wb_rd_write(s_wb_rd_write), .wb_rd_addr(s_wb_rd_addr), .wb_exc(s_wb_exc),
        .wb_exc_code(s_wb_code), .wb_exc_tval(s_wb_tval), .mem_rd_write(s_fwd_write),
        .mem_rd_addr(s_fwd_addr), .mem_rd_wdata(s_fwd_data), .mem_hazard(s_hazard)
    );

    mem_lsu #(.XLEN(64), .REG_AW(5), .DEPTH(2)) u_dut64 (
        .clk(clk), .rst(rst), .ex_valid(d_ex_valid), .ex_ready(d_ex_ready),
        .ex_pc(d_pc), .ex_addr(d_addr), .ex_wdata(d_wdata), .ex_alu_result(d_alu),
        .ex_mem_read(d_mem_read), .ex_mem_write(d_mem_write), .ex_unsign(d_unsign),
        .ex_size(d_size), .ex_rd_write(d_rd_write), .ex_rd_addr(d_rd_addr), .flush(d_flush),
        .dram_req(d_req), .dram_we(d_we), .dram_gnt(d_gnt), .dram_addr(d_daddr),
        .dram_wdata(d_dwdata), .dram_wstrb(d_wstrb), .dram_rvalid(d_rvalid), .dram_rdata(d_rdata),
        .wb_valid(d_wb_valid), .wb_ready(d_wb_ready), .wb_pc(d_wb_pc), .wb_rd_data(d_wb_data),
        .wb_rd_write(d_wb_rd_write), .wb_rd_addr(d_wb_rd_addr), .wb_exc(d_wb_exc),
        .wb_exc_code(d_wb_code), .wb_exc_tval(d_wb_tval), .mem_rd_write(d_fwd_write),
        .mem_rd_addr(d_fwd_addr), .mem_rd_wdata(d_fwd_data), .mem_hazard(d_hazard)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic s_idle();
        s_ex_valid = 0; s_mem_read = 0; s_mem_write = 0; s_unsign = 0; s_rd_write = 0;
        s_gnt = 0; s_rvalid = 0; s_flush = 0;
    endtask

    task automatic s_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdat, input logic [31:0] alu,
                        input logic rdw, input logic gnt);
        s_ex_valid = 1; s_mem_read = rd; s_mem_write = wr; s_size = sz; s_unsign = uns;
        s_addr = addr; s_wdata = wdat; s_alu = alu; s_rd_write = rdw; s_rd_addr = 5'd7;
        s_pc = 32'h40 + addr; s_gnt = gnt;
    endtask

    // Load issued and granted, response three edges after the accept.
    task automatic s_load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] rdata, input logic [31:0] exp);
        s_op(1, 0, sz, uns, addr, 0, 0, 1, 1);
        #1 check_val({tag, "_req"}, {s_req, s_we, s_daddr}, {1'b1, 1'b0, addr & 32'hFFFF_FFFC});
        step();
        s_idle();
        #1 check_val({tag, "_hazard"}, s_hazard, 1'b1);
        step();
        step();
        s_rvalid = 1; s_rdata = rdata;
        #1 check_val({tag, "_wait"}, s_wb_valid, 1'b0);
        step();
        s_rvalid = 0;
        #1 check_val({tag, "_data"}, {s_wb_valid, s_fwd_write, s_hazard, s_wb_data},
                     {1'b1, 1'b1, 1'b0, exp});
        step();
    endtask

    task automatic d_load(input string tag, input logic [63:0] addr, input logic [1:0] sz,
                          input logic uns, input logic [63:0] rdata, input logic [63:0] exp);
        d_ex_valid = 1; d_mem_read = 1; d_size = sz; d_unsign = uns; d_addr = addr;
        d_rd_write = 1; d_rd_addr = 5'd3; d_gnt = 1;
        #1 check_val({tag, "_addr"}, {d_req, d_daddr}, {1'b1, addr & 64'hFFFF_FFFF_FFFF_FFF8});
        step();
        d_ex_valid = 0; d_mem_read = 0; d_gnt = 0;
        d_rvalid = 1; d_rdata = rdata;
        step();
        d_rvalid = 0;
        #1 check_val({tag, "_data"}, {7'd0, d_wb_valid, d_wb_data[63:8]}, {7'd0, 1'b1, exp[63:8]});
        check_val({tag, "_lo"}, d_wb_data[7:0], exp[7:0]);
        step();
    endtask

    initial begin
        rst = 1;
        s_idle();
        s_pc = 0; s_addr = 0; s_wdata = 0; s_alu = 0; s_size = 0; s_rd_addr = 0; s_rdata = 0;
        s_wb_ready = 1;
        d_ex_valid = 0; d_mem_read = 0; d_mem_write = 0; d_unsign = 0; d_rd_write = 0;
        d_pc = 0; d_addr = 0; d_wdata = 0; d_alu = 0; d_size = 0; d_rd_addr = 0;
        d_flush = 0; d_gnt = 0; d_rvalid = 0; d_rdata = 0; d_wb_ready = 1;
        step();
        step();
        check_val("reset32", {s_wb_valid, s_req, s_hazard, s_fwd_write, s_wb_exc}, 5'b0);
        check_val("reset64", {d_wb_valid, d_req, d_hazard, d_fwd_write, d_wb_exc}, 5'b0);
        rst = 0;
        step();

        // load latency and extension
        s_load("lw",  32'h100, 2'd2, 1'b0, 32'h8000_00F1, 32'h8000_00F1);
        s_load("lb",  32'h100, 2'd0, 1'b0, 32'h8000_00F1, 32'hFFFF_FFF1);
        s_load("lbu", 32'h100, 2'd0, 1'b1, 32'h8000_00F1, 32'h0000_00F1);
        s_load("lh2", 32'h102, 2'd1, 1'b0, 32'h8765_4321, 32'hFFFF_8765);
        s_load("lbu3", 32'h103, 2'd0, 1'b1, 32'h8765_4321, 32'h0000_0087);

        // two outstanding loads, full FIFO blocks a third op even while popping
        s_wb_ready = 0;
        s_op(1, 0, 2'd2, 0, 32'h200, 0, 0, 1, 1);
        step();
        s_op(1, 0, 2'd2, 0, 32'h204, 0, 0, 1, 1);
        #1 check_val("ld2_req", s_req, 1'b1);
        step();
        s_op(0, 0, 2'd2, 0, 32'h0, 0, 32'h1234_5678, 1, 0);
        #1 check_val("full_ready", s_ex_ready, 1'b0);
        s_rvalid = 1; s_rdata = 32'hAAAA_0001;
        step();
        s_rdata = 32'hBBBB_0002;
        #1 check_val("retire_a", {s_wb_valid, s_wb_data}, {1'b1, 32'hAAAA_0001});
        step();
        s_rvalid = 0;
        s_wb_ready = 1;
        #1 check_val("full_pop_ready", s_ex_ready, 1'b0);
        step();
        #1 check_val("retire_b", {s_wb_valid, s_wb_data, s_ex_ready}, {1'b1, 32'hBBBB_0002, 1'b1});
        step();
        s_idle();
        #1 check_val("alu_retire", {s_wb_valid, s_wb_data}, {1'b1, 32'h1234_5678});
        step();
        check_val("drained", s_wb_valid, 1'b0);

        // store byte lanes
        s_op(0, 1, 2'd1, 0, 32'h102, 32'h0000_1234, 0, 0, 1);
        #1 check_val("sh_lanes", {s_req, s_we, s_wstrb, s_dwdata, s_daddr},
                     {1'b1, 1'b1, 4'b1100, 32'h1234_1234, 32'h100});
        step();
        s_idle();
        #1 check_val("sh_retire", {s_wb_valid, s_wb_exc, s_hazard}, 3'b100);
        step();

        // store waits for an empty FIFO
        s_wb_ready = 0;
        s_op(0, 0, 2'd2, 0, 32'h0, 0, 32'h55, 0, 0);
        step();
        s_op(0, 1, 2'd2, 0, 32'h10C, 32'hDEAD_BEEF, 0, 0, 1);
        #1 check_val("st_blocked", {s_req, s_ex_ready}, 2'b00);
        s_wb_ready = 1;
        step();
        #1 check_val("st_issue", {s_req, s_wstrb, s_dwdata}, {1'b1, 4'b1111, 32'hDEAD_BEEF});
        step();
        s_idle();
        step();

        // misaligned load and store
        s_op(1, 0, 2'd2, 0, 32'h101, 0, 0, 1, 0);
        #1 check_val("lw_mis_req", {s_req, s_ex_ready}, 2'b01);
        step();
        s_idle();
        #1 check_val("lw_mis_exc", {s_wb_valid, s_wb_exc, s_wb_code, s_wb_tval},
                     {1'b1, 1'b1, 4'd4, 32'h101});
        step();
        s_op(0, 1, 2'd2, 0, 32'h102, 0, 0, 0, 0);
        #1 check_val("sw_mis_req", s_req, 1'b0);
        step();
        s_idle();
        #1 check_val("sw_mis_exc", {s_wb_valid, s_wb_exc, s_wb_code, s_wb_tval},
                     {1'b1, 1'b1, 4'd6, 32'h102});
        step();

        // flush with two loads outstanding drains their responses
        s_op(1, 0, 2'd2, 0, 32'h300, 0, 0, 1, 1);
        step();
        s_op(1, 0, 2'd2, 0, 32'h304, 0, 0, 1, 1);
        step();
        s_idle();
        s_flush = 1;
        step();
        s_flush = 0;
        #1 check_val("flush_clear", {s_wb_valid, s_hazard}, 2'b00);
        s_op(1, 0, 2'd2, 0, 32'h308, 0, 0, 1, 1);
        #1 check_val("post_flush_req", s_req, 1'b1);
        step();
        s_idle();
        s_rvalid = 1; s_rdata = 32'h0000_1111;
        step();
        s_rdata = 32'h0000_2222;
        #1 check_val("drop1", s_wb_valid, 1'b0);
        step();
        s_rdata = 32'h0000_CAFE;
        #1 check_val("drop2", s_wb_valid, 1'b0);
        step();
        s_rvalid = 0;
        #1 check_val("cafe", {s_wb_valid, s_wb_data}, {1'b1, 32'h0000_CAFE});
        step();

        // RV64 loads and a byte store
        d_load("ld",  64'h8, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        d_load("lwu", 64'h4, 2'd2, 1'b1, 64'hFFFF_0000_1234_5678, 64'h0000_0000_FFFF_0000);
        d_load("lw",  64'h4, 2'd2, 1'b0, 64'hFFFF_0000_1234_5678, 64'hFFFF_FFFF_FFFF_0000);
        d_ex_valid = 1; d_mem_write = 1; d_size = 2'd0; d_addr = 64'h5; d_wdata = 64'hAB;
        d_rd_write = 0; d_gnt = 1;
        #1 check_val("sb64_strb", {56'd0, d_wstrb}, 64'h20);
        check_val("sb64_data", d_dwdata, 64'hABAB_ABAB_ABAB_ABAB);
        step();
        d_ex_valid = 0; d_mem_write = 0; d_gnt = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
